aos_strm_tx: RTL and testbench

Transmit-side companion to the AOS stream wrapper. It accepts 32-bit words written over the bus-side word interface and buffers them in a small word FIFO. It serializes each word into 8-bit AXI4-Stream beats, least-significant byte first, framed to `frame_width` bytes with `last`. It drives the AOS core's stream-input port, or any AXI4-Stream byte sink.

---
 rtl/aos_pkg.sv | 15 +
 rtl/aos_tx_fifo.sv | 76 +++++++
 rtl/aos_strm_tx.sv | 141 ++++++++++++++
 tb/tb_aos_strm_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aos_pkg.sv
// Shared constants and types for the AOS transmit stream path.
//   AOS_WORD_BYTES : bytes per bus word fed to the serializer
//   AOS_FW_WIDTH   : width of the frame-width field and byte counter
//   aos_tx_state_e : serializer FSM state encoding
package aos_pkg;

    localparam int AOS_WORD_BYTES = 4;
    localparam int AOS_FW_WIDTH   = 9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } aos_tx_state_e;

endpackage

// File: rtl/aos_tx_fifo.sv
// Synchronous word FIFO with count-based full/empty flags.
// Storage is a register array; pop_data_o is the registered head entry and is
// valid whenever empty_o is low.
//   clk, rst          : clock, asynchronous active-low reset
//   push_i, push_data_i : write strobe and word (ignored while full)
//   pop_i             : consume the head word (ignored while empty)
//   pop_data_o        : head word
//   full_o, empty_o   : occupancy flags
module aos_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == CNT_FULL);
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: an entry is only read after it is written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/aos_strm_tx.sv
// AOS transmit stream: buffers 32-bit bus words and serializes them into
// 8-bit AXI4-Stream beats, least-significant byte first, framed to
// frame_width bytes with last. A frame never shares a word: when last is
// sent mid-word the remaining bytes of that word are dropped.
//   clk, rst            : clock, asynchronous active-low reset
//   frame_width         : bytes per frame, latched at each frame's first word (0 acts as 1)
//   word_*              : bus-side word write (valid/ready)
//   axi4_strm_out_*     : byte stream to the sink
//   frame_done_o        : pulses while the last beat handshakes
//   busy_o              : FIFO non-empty or a word is being sent
//
// state | meaning
// IDLE  | no word held; pop the FIFO head as soon as one is present
// SEND  | word_q holds a word; presenting byte byte_idx_q on the stream
module aos_strm_tx
    import aos_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int OUT_NBYTE      = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int FW_WIDTH       = AOS_FW_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FW_WIDTH-1:0]       frame_width,
    input  logic [AXI_DATA_WIDTH-1:0] word_wdata_i,
    input  logic                      word_valid_i,
    output logic                      word_ready_o,
    output logic [OUT_NBYTE*8-1:0]    axi4_strm_out_data,
    output logic                      axi4_strm_out_valid,
    input  logic                      axi4_strm_out_ready,
    output logic [OUT_NBYTE-1:0]      axi4_strm_out_keep,
    output logic                      axi4_strm_out_last,
    output logic                      frame_done_o,
    output logic                      busy_o
);
    localparam int                  IDX_W    = $clog2(AOS_WORD_BYTES);
    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(AOS_WORD_BYTES - 1);
    localparam logic [FW_WIDTH-1:0] FW_ONE   = FW_WIDTH'(1);

    aos_tx_state_e             state_q, state_d;
    logic [AXI_DATA_WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0]          byte_idx_q, byte_idx_d;
    logic [FW_WIDTH-1:0]       byte_cnt_q, byte_cnt_d;
    logic [FW_WIDTH-1:0]       frame_w_lat_q, frame_w_lat_d;

    logic [AXI_DATA_WIDTH-1:0] fifo_rdata;
    logic                      fifo_full, fifo_empty, fifo_pop;
    logic                      sending, beat_hs, last_beat, word_done;

    aos_tx_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (word_valid_i),
        .push_data_i (word_wdata_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign sending   = (state_q == SEND);
    assign beat_hs   = sending && axi4_strm_out_ready;
    assign last_beat = sending && (byte_cnt_q == frame_w_lat_q - FW_ONE);
    assign word_done = beat_hs && (last_beat || byte_idx_q == IDX_LAST);
    // Refill on the same edge the current word finishes, so back-to-back
    // words stream without a bubble.
    assign fifo_pop  = !fifo_empty && (!sending || word_done);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SEND;
            SEND:    if (word_done && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Serializer datapath
    always_comb begin
        word_d        = word_q;
        byte_idx_d    = byte_idx_q;
        byte_cnt_d    = byte_cnt_q;
        frame_w_lat_d = frame_w_lat_q;
        if (beat_hs) begin
            byte_idx_d = byte_idx_q + IDX_ONE;
            byte_cnt_d = last_beat ? '0 : byte_cnt_q + FW_ONE;
        end
        if (fifo_pop) begin
            word_d     = fifo_rdata;
            byte_idx_d = '0;
            // A zero count after this edge means the popped word opens a frame.
            if (byte_cnt_d == '0) begin
                frame_w_lat_d = (frame_width == '0) ? FW_ONE : frame_width;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q        <= '0;
            byte_idx_q    <= '0;
            byte_cnt_q    <= '0;
            frame_w_lat_q <= '0;
        end else begin
            word_q        <= word_d;
            byte_idx_q    <= byte_idx_d;
            byte_cnt_q    <= byte_cnt_d;
            frame_w_lat_q <= frame_w_lat_d;
        end
    end

    // Outputs: all derived from registers, so they hold while the sink stalls.
    always_comb begin
        word_ready_o        = !fifo_full;
        axi4_strm_out_valid = sending;
        axi4_strm_out_keep  = {OUT_NBYTE{sending}};
        axi4_strm_out_data  = '0;
        if (sending) begin
            axi4_strm_out_data = word_q[{byte_idx_q, 3'b000} +: OUT_NBYTE*8];
        end
        axi4_strm_out_last  = last_beat;
        frame_done_o        = beat_hs && last_beat;
        busy_o              = !fifo_empty || sending;
    end

endmodule

// File: tb/tb_aos_strm_tx.sv
// Directed bench for aos_strm_tx with a byte-stream reference model.
module tb_aos_strm_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  frame_width = 9'd8;
    logic [31:0] word_wdata_i = '0;
    logic        word_valid_i = 1'b0;
    logic        word_ready_o;
    logic [7:0]  axi4_strm_out_data;
    logic        axi4_strm_out_valid;
    logic        axi4_strm_out_ready = 1'b0;
    logic [0:0]  axi4_strm_out_keep;
    logic        axi4_strm_out_last;
    logic        frame_done_o;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: accepted words in order, current byte position within
    // the head word, byte count within the frame, and the frame's width.
    logic [31:0] wq[$];
    int          pos    = 0;
    int          fc     = 0;
    int          fw     = 1;
    bit          fw_set = 1'b0;
    logic [7:0]  eb;
    bit          el;

    logic [7:0]  got_q[$];
    bit          got_last[$];
    int          done_cnt = 0;
    logic [7:0]  exp_b[$];
    int          exp_li[$];

    always #5 clk = ~clk;

    aos_strm_tx dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_width         (frame_width),
        .word_wdata_i        (word_wdata_i),
        .word_valid_i        (word_valid_i),
        .word_ready_o        (word_ready_o),
        .axi4_strm_out_data  (axi4_strm_out_data),
        .axi4_strm_out_valid (axi4_strm_out_valid),
        .axi4_strm_out_ready (axi4_strm_out_ready),
        .axi4_strm_out_keep  (axi4_strm_out_keep),
        .axi4_strm_out_last  (axi4_strm_out_last),
        .frame_done_o        (frame_done_o),
        .busy_o              (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_valid", axi4_strm_out_valid, 0);
            check("rst_data", axi4_strm_out_data, 0);
            check("rst_last", axi4_strm_out_last, 0);
            check("rst_keep", axi4_strm_out_keep, 0);
            check("rst_done", frame_done_o, 0);
            check("rst_busy", busy_o, 0);
            wq.delete();
            pos    = 0;
            fc     = 0;
            fw_set = 1'b0;
        end else begin
            if (axi4_strm_out_valid) begin
                if (wq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stray_valid: got valid=1 data %0h, expected no beat pending",
                             axi4_strm_out_data);
                end else begin
                    if (!fw_set) begin
                        fw     = (frame_width == 0) ? 1 : int'(frame_width);
                        fw_set = 1'b1;
                    end
                    eb = 8'(wq[0] >> (8 * pos));
                    el = (fc == fw - 1);
                    check("data", axi4_strm_out_data, eb);
                    check("last", axi4_strm_out_last, el);
                    check("keep", axi4_strm_out_keep, 1);
                    check("frame_done", frame_done_o, el && axi4_strm_out_ready);
                    if (axi4_strm_out_ready) begin
                        got_q.push_back(axi4_strm_out_data);
                        got_last.push_back(axi4_strm_out_last);
                        fc++;
                        pos++;
                        if (el) begin
                            fc     = 0;
                            pos    = 0;
                            fw_set = 1'b0;
                            void'(wq.pop_front());
                        end else if (pos == 4) begin
                            pos = 0;
                            void'(wq.pop_front());
                        end
                    end
                end
            end else begin
                check("idle_data", axi4_strm_out_data, 0);
                check("idle_last", axi4_strm_out_last, 0);
                check("idle_keep", axi4_strm_out_keep, 0);
                check("idle_done", frame_done_o, 0);
            end
            if (frame_done_o) done_cnt++;
            if (word_valid_i && word_ready_o) wq.push_back(word_wdata_i);
        end
    end

    task automatic clear_log();
        got_q.delete();
        got_last.delete();
        done_cnt = 0;
    endtask

    task automatic write_word(input logic [31:0] w);
        int n = 0;
        word_valid_i = 1'b1;
        word_wdata_i = w;
        while (!word_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("write_timeout", 1, 0);
        tick();
        word_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_idle_busy"}, busy_o, 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!axi4_strm_out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_wait_valid"}, axi4_strm_out_valid, 1);
    endtask

    // Compares the logged stream with exp_b; exp_li lists the indices carrying last.
    task automatic check_stream(input string tag);
        bit want_last;
        check({tag, "_len"}, got_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_q.size(); i++) begin
            want_last = 1'b0;
            foreach (exp_li[k]) if (exp_li[k] == i) want_last = 1'b1;
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_b[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i], want_last);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles, released just after an edge.
        rst = 1'b0;
        repeat (3) tick();
        check("t1_valid", axi4_strm_out_valid, 0);
        check("t1_busy", busy_o, 0);
        rst = 1'b1;
        tick();
        check("t1_word_ready", word_ready_o, 1);
        check("t1_busy_after", busy_o, 0);

        // Two words, one 8-byte frame, checking first-byte latency.
        frame_width = 9'd8;
        axi4_strm_out_ready = 1'b1;
        clear_log();
        write_word(32'h44332211);
        check("t2_lat_n1_valid", axi4_strm_out_valid, 0);
        write_word(32'h88776655);
        check("t2_lat_n2_valid", axi4_strm_out_valid, 1);
        check("t2_lat_n2_data", axi4_strm_out_data, 8'h11);
        wait_idle("t2");
        exp_b  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        exp_li = {7};
        check_stream("t2");
        check("t2_done_pulses", done_cnt, 1);

        // 6-byte frames: tail of the second word is dropped.
        frame_width = 9'd6;
        clear_log();
        write_word(32'h44332211);
        write_word(32'h88776655);
        write_word(32'hDDCCBBAA);
        write_word(32'h12345678);
        wait_idle("t3");
        exp_b  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h78, 8'h56};
        exp_li = {5, 11};
        check_stream("t3");
        check("t3_done_pulses", done_cnt, 2);

        // Backpressure at the third byte.
        frame_width = 9'd4;
        axi4_strm_out_ready = 1'b0;
        clear_log();
        write_word(32'h44332211);
        wait_valid("t4");
        axi4_strm_out_ready = 1'b1;
        tick();
        tick();
        axi4_strm_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold_data%0d", i), axi4_strm_out_data, 8'h33);
            check($sformatf("t4_hold_valid%0d", i), axi4_strm_out_valid, 1);
            check($sformatf("t4_hold_last%0d", i), axi4_strm_out_last, 0);
            tick();
        end
        axi4_strm_out_ready = 1'b1;
        check("t4_resume_data", axi4_strm_out_data, 8'h33);
        tick();
        check("t4_final_data", axi4_strm_out_data, 8'h44);
        check("t4_final_last", axi4_strm_out_last, 1);
        check("t4_final_done", frame_done_o, 1);
        tick();
        wait_idle("t4");
        exp_b  = {8'h11, 8'h22, 8'h33, 8'h44};
        exp_li = {3};
        check_stream("t4");
        check("t4_done_pulses", done_cnt, 1);

        // Fill to capacity with the sink stalled: 4 FIFO words + 1 held.
        frame_width = 9'd16;
        axi4_strm_out_ready = 1'b0;
        clear_log();
        for (int i = 0; i < 7; i++) begin
            word_valid_i = 1'b1;
            word_wdata_i = 32'h03020100 + 32'(i) * 32'h04040404;
            check($sformatf("t5_ready_w%0d", i), word_ready_o, (i < 5) ? 1 : 0);
            tick();
        end
        word_wdata_i = 32'h03020100 + 32'd5 * 32'h04040404;
        axi4_strm_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_full_hs%0d", k), word_ready_o, 0);
            tick();
        end
        check("t5_ready_after_word", word_ready_o, 1);
        tick();
        word_valid_i = 1'b0;
        wait_idle("t5");
        exp_b.delete();
        for (int j = 0; j < 24; j++) exp_b.push_back(8'(j));
        exp_li = {15};
        check_stream("t5");
        check("t5_done_pulses", done_cnt, 1);

        // Reset in the middle of a frame, then a fresh frame.
        frame_width = 9'd8;
        axi4_strm_out_ready = 1'b1;
        clear_log();
        write_word(32'h44332211);
        write_word(32'h88776655);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t6_async_valid", axi4_strm_out_valid, 0);
        check("t6_async_data", axi4_strm_out_data, 0);
        check("t6_async_last", axi4_strm_out_last, 0);
        check("t6_async_busy", busy_o, 0);
        tick();
        tick();
        rst = 1'b1;
        clear_log();
        tick();
        check("t6_word_ready", word_ready_o, 1);
        write_word(32'hDDCCBBAA);
        write_word(32'h44332211);
        wait_idle("t6");
        exp_b  = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_li = {7};
        check_stream("t6");
        check("t6_done_pulses", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
